// File: rtl/mem_read_responder_pkg.sv
// Shared definitions for the memory read responder: word/address widths,
// FSM state encoding and the address range check used by MEM_RESP_ADDR_CHECK_EN.
package mem_read_responder_pkg;

    localparam int MEM_WORD_W = 32;
    localparam int MEM_ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } mem_state_e;

    // An address is bad when it is not word aligned or lies beyond the stored words.
    function automatic logic addr_out_of_range(input logic [MEM_ADDR_W-1:0] addr,
                                               input int depth_log2);
        logic [MEM_ADDR_W-1:0] upper;
        upper = addr >> (depth_log2 + 2);
        return (upper != '0) || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Word storage for mem_read_responder: one synchronous preload write port and
// one combinational read port that the FSM samples on request acceptance.
module mem_resp_array
    import mem_read_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_idx,
    input  logic [MEM_WORD_W-1:0] wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_idx,
    output logic [MEM_WORD_W-1:0] rd_data
);

    logic [MEM_WORD_W-1:0] mem_q [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    // Reading the pre-edge contents gives read-before-write on a same-word collision.
    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/mem_read_responder.sv
// Memory-side read responder: accepts a word read, waits MEM_LATENCY cycles, pulses
// mem_valid_out with the word. Optional MEM_RESP_ADDR_CHECK_EN adds mem_err_out.
module mem_read_responder
    import mem_read_responder_pkg::*;
#(
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int MEM_LATENCY    = 2
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  mem_read_in,
    input  logic [MEM_ADDR_W-1:0] mem_addr_in,
    output logic [MEM_WORD_W-1:0] mem_data_out,
    output logic                  mem_valid_out,
    output logic                  mem_busy_out,
    input  logic                  load_we_in,
    input  logic [MEM_ADDR_W-1:0] load_addr_in,
    input  logic [MEM_WORD_W-1:0] load_data_in
`ifdef MEM_RESP_ADDR_CHECK_EN
    ,
    output logic                  mem_err_out
`endif
);

    localparam logic [3:0] CNT_LOAD = 4'((MEM_LATENCY >= 2) ? (MEM_LATENCY - 2) : 0);

    mem_state_e            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [MEM_WORD_W-1:0] snap_q, snap_d;
    logic [MEM_WORD_W-1:0] data_q, data_d;
    logic                  valid_q, valid_d;

    logic [MEM_WORD_W-1:0] rd_word;
    logic [MEM_WORD_W-1:0] acc_word;
    logic                  acc_err;
    logic                  wr_en;

`ifdef MEM_RESP_ADDR_CHECK_EN
    logic err_q, err_d;
    logic snap_err_q, snap_err_d;

    assign acc_err = addr_out_of_range(mem_addr_in, MEM_DEPTH_LOG2);
    assign wr_en   = load_we_in && !addr_out_of_range(load_addr_in, MEM_DEPTH_LOG2);
    assign mem_err_out = err_q;
`else
    logic unused_addr_bits;

    // Upper and byte-offset bits are don't-care here: addresses alias onto the array.
    assign unused_addr_bits = ^{mem_addr_in[MEM_ADDR_W-1:MEM_DEPTH_LOG2+2], mem_addr_in[1:0],
                                load_addr_in[MEM_ADDR_W-1:MEM_DEPTH_LOG2+2], load_addr_in[1:0]};
    assign acc_err = 1'b0;
    assign wr_en   = load_we_in;
`endif

    mem_resp_array #(
        .DEPTH_LOG2(MEM_DEPTH_LOG2)
    ) u_array (
        .clk     (clock_in),
        .wr_en   (wr_en),
        .wr_idx  (load_addr_in[MEM_DEPTH_LOG2+1:2]),
        .wr_data (load_data_in),
        .rd_idx  (mem_addr_in[MEM_DEPTH_LOG2+1:2]),
        .rd_data (rd_word)
    );

    assign acc_word = acc_err ? '0 : rd_word;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        data_d  = data_q;
        valid_d = 1'b0;
`ifdef MEM_RESP_ADDR_CHECK_EN
        err_d      = 1'b0;
        snap_err_d = snap_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (mem_read_in) begin
                    snap_d = acc_word;
`ifdef MEM_RESP_ADDR_CHECK_EN
                    snap_err_d = acc_err;
`endif
                    if (MEM_LATENCY == 1) begin
                        state_d = ST_RESP;
                        data_d  = acc_word;
                        valid_d = 1'b1;
`ifdef MEM_RESP_ADDR_CHECK_EN
                        err_d = acc_err;
`endif
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    data_d  = snap_q;
                    valid_d = 1'b1;
`ifdef MEM_RESP_ADDR_CHECK_EN
                    err_d = snap_err_q;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            snap_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
`ifdef MEM_RESP_ADDR_CHECK_EN
            err_q      <= 1'b0;
            snap_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            data_q  <= data_d;
            valid_q <= valid_d;
`ifdef MEM_RESP_ADDR_CHECK_EN
            err_q      <= err_d;
            snap_err_q <= snap_err_d;
`endif
        end
    end

    assign mem_data_out  = data_q;
    assign mem_valid_out = valid_q;
    assign mem_busy_out  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_read_responder.sv
// Bench for mem_read_responder: three instances (latency 2, 1, 15) driven with
// directed and random reads/preloads, checked against a word-array reference model.
module tb_mem_read_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  rd, we, valid, busy;
    logic [31:0] addr [3];
    logic [31:0] data [3];
    logic [31:0] la   [3];
    logic [31:0] ld   [3];
`ifdef MEM_RESP_ADDR_CHECK_EN
    logic [2:0]  err;
`endif

    logic [31:0] ref_mem [3][1024];
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_read_responder #(.MEM_DEPTH_LOG2(10), .MEM_LATENCY(2)) dut (
        .clock_in(clk), .reset_in(rst), .mem_read_in(rd[0]), .mem_addr_in(addr[0]),
        .mem_data_out(data[0]), .mem_valid_out(valid[0]), .mem_busy_out(busy[0]),
        .load_we_in(we[0]), .load_addr_in(la[0]), .load_data_in(ld[0])
`ifdef MEM_RESP_ADDR_CHECK_EN
        , .mem_err_out(err[0])
`endif
    );

    mem_read_responder #(.MEM_DEPTH_LOG2(4), .MEM_LATENCY(1)) dut_l1 (
        .clock_in(clk), .reset_in(rst), .mem_read_in(rd[1]), .mem_addr_in(addr[1]),
        .mem_data_out(data[1]), .mem_valid_out(valid[1]), .mem_busy_out(busy[1]),
        .load_we_in(we[1]), .load_addr_in(la[1]), .load_data_in(ld[1])
`ifdef MEM_RESP_ADDR_CHECK_EN
        , .mem_err_out(err[1])
`endif
    );

    mem_read_responder #(.MEM_DEPTH_LOG2(4), .MEM_LATENCY(15)) dut_l15 (
        .clock_in(clk), .reset_in(rst), .mem_read_in(rd[2]), .mem_addr_in(addr[2]),
        .mem_data_out(data[2]), .mem_valid_out(valid[2]), .mem_busy_out(busy[2]),
        .load_we_in(we[2]), .load_addr_in(la[2]), .load_data_in(ld[2])
`ifdef MEM_RESP_ADDR_CHECK_EN
        , .mem_err_out(err[2])
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: per-instance depth/latency and address rules.
    function automatic int dl_of(input int i);
        return (i == 0) ? 10 : 4;
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 15);
    endfunction

    function automatic int idx_of(input int i, input logic [31:0] a);
        return int'((a / 4) % (32'd1 << dl_of(i)));
    endfunction

    function automatic bit err_of(input int i, input logic [31:0] a);
`ifdef MEM_RESP_ADDR_CHECK_EN
        return ((a >> (dl_of(i) + 2)) != 0) || ((a % 4) != 0);
`else
        return (i < 0) && (a != a);
`endif
    endfunction

    function automatic logic [31:0] rand_addr(input int i);
        int depth;
        depth = 1 << dl_of(i);
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 4 * depth - 1));
            default: return 32'($urandom_range(0, depth - 1) * 4);
        endcase
    endfunction

    task automatic step();
        @(negedge clk);
        we = '0;
    endtask

    // Drives a preload for the coming edge and records its effect in the model.
    task automatic drive_write(input int i, input logic [31:0] a, input logic [31:0] d);
        we[i] = 1'b1;
        la[i] = a;
        ld[i] = d;
        if (!err_of(i, a)) ref_mem[i][idx_of(i, a)] = d;
    endtask

    task automatic preload(input int i, input logic [31:0] a, input logic [31:0] d);
        step();
        drive_write(i, a, d);
    endtask

    task automatic do_read(input int i, input logic [31:0] a, input bit toggle,
                           input bit same_wr, input logic [31:0] wdata);
        logic [31:0] exp_w;
        bit          exp_err;
        bit          got;
        int          lat;
        step();
        rd[i]   = 1'b1;
        addr[i] = a;
        exp_err = err_of(i, a);
        exp_w   = exp_err ? 32'h0 : ref_mem[i][idx_of(i, a)];
        exp_q.push_back(exp_w);
        if (same_wr) drive_write(i, a, wdata);
        got = 1'b0;
        lat = 0;
        while (!got && lat < 40) begin
            step();
            lat++;
            check("busy_pending", 32'(busy[i]), 32'd1);
            if (valid[i]) begin
                got = 1'b1;
                check("latency", 32'(lat), 32'(lat_of(i)));
                check("read_data", data[i], exp_q.pop_front());
`ifdef MEM_RESP_ADDR_CHECK_EN
                check("err_flag", 32'(err[i]), 32'(exp_err));
`endif
                rd[i] = 1'b0;
            end else if (toggle) begin
                rd[i] = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 2) == 0) drive_write(i, rand_addr(i), $urandom);
        end
        if (!got) begin
            check("valid_timeout", 32'd0, 32'd1);
            exp_q.delete();
            rd[i] = 1'b0;
        end
        step();
        check("valid_one_cycle", 32'(valid[i]), 32'd0);
        check("busy_after", 32'(busy[i]), 32'd0);
    endtask

    task automatic wait_valid(input int i, output int at_cyc, output bit ok);
        ok = 1'b0;
        at_cyc = 0;
        for (int n = 0; n < 40 && !ok; n++) begin
            step();
            if (valid[i]) begin
                ok = 1'b1;
                at_cyc = cyc;
            end
        end
    endtask

    initial begin
        int  c1, c2, pulses;
        bit  ok;
        rd = '0;
        we = '0;
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0;
            la[i]   = '0;
            ld[i]   = '0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_valid", 32'(valid[i]), 32'd0);
            check("rst_busy", 32'(busy[i]), 32'd0);
            check("rst_data", data[i], 32'd0);
`ifdef MEM_RESP_ADDR_CHECK_EN
            check("rst_err", 32'(err[i]), 32'd0);
`endif
        end
        rst = 1'b0;

        // Fill every word so that every model entry is defined.
        for (int w = 0; w < 1024; w++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                if (w < (1 << dl_of(i))) drive_write(i, 32'(w * 4), $urandom);
            end
        end

        // Basic read at latency 2.
        preload(0, 32'h0C, 32'hDEADBEEF);
        do_read(0, 32'h0C, 1'b0, 1'b0, 32'h0);

        // Reset during WAIT drops the request.
        step();
        rd[0]   = 1'b1;
        addr[0] = 32'h0;
        @(posedge clk);
        #1;
        check("busy_before_rst", 32'(busy[0]), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 32'(valid[0]), 32'd0);
        check("rst_mid_busy", 32'(busy[0]), 32'd0);
        check("rst_mid_data", data[0], 32'd0);
        step();
        rd[0] = 1'b0;
        step();
        rst = 1'b0;
        pulses = 0;
        repeat (8) begin
            step();
            if (valid[0] || busy[0]) pulses++;
        end
        check("rst_no_valid", 32'(pulses), 32'd0);

        // Back-to-back with read held high.
        preload(0, 32'h0, 32'h11);
        preload(0, 32'h4, 32'h22);
        step();
        rd[0]   = 1'b1;
        addr[0] = 32'h0;
        wait_valid(0, c1, ok);
        check("b2b_first_seen", 32'(ok), 32'd1);
        check("b2b_first_data", data[0], 32'h11);
        addr[0] = 32'h4;
        wait_valid(0, c2, ok);
        check("b2b_second_seen", 32'(ok), 32'd1);
        check("b2b_second_data", data[0], 32'h22);
        check("b2b_spacing", 32'(c2 - c1), 32'(lat_of(0) + 1));
        rd[0] = 1'b0;
        pulses = 0;
        repeat (8) begin
            step();
            if (valid[0]) pulses++;
        end
        check("b2b_no_extra", 32'(pulses), 32'd0);

        // Read-before-write on the acceptance edge.
        preload(0, 32'h14, 32'hAAAA);
        do_read(0, 32'h14, 1'b0, 1'b1, 32'hBBBB);
        do_read(0, 32'h14, 1'b0, 1'b0, 32'h0);

        // Latency extremes with mem_read_in toggling while waiting.
        do_read(1, 32'h8, 1'b1, 1'b0, 32'h0);
        do_read(2, 32'hC, 1'b1, 1'b0, 32'h0);

        // Out-of-range and unaligned addresses (alias or error depending on build).
        do_read(0, 32'h0000_1000, 1'b0, 1'b0, 32'h0);
        do_read(0, 32'h2, 1'b0, 1'b0, 32'h0);

        for (int n = 0; n < 40; n++) begin
            int i;
            i = $urandom_range(0, 2);
            do_read(i, rand_addr(i), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
